// File: rtl/cell_colour_map.sv
`default_nettype none
// ============================================================================
// Module   : cell_colour_map
// Brief    : Keypad-driven per-cell colour registers feeding the VGA pixel path.
//            Define CELL_COLOUR_PALETTE_WR_EN to make the 4-entry palette writable.
// Revision : 1.0 - initial release
// ============================================================================
module cell_colour_map #(
    parameter int NUM_CELLS   = 9,
    parameter int CW          = 3,
    parameter int CODE_W      = 4,
    parameter int COL_BASE    = 10,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    code_valid,
    input  logic [CODE_W-1:0]       code,
`ifdef CELL_COLOUR_PALETTE_WR_EN
    input  logic                    pal_we,
    input  logic [1:0]              pal_idx,
    input  logic [3*CW-1:0]         pal_data,
`endif
    output logic [NUM_CELLS*CW-1:0] reds,
    output logic [NUM_CELLS*CW-1:0] greens,
    output logic [NUM_CELLS*CW-1:0] blues,
    output logic [CODE_W-1:0]       sel_cell,
    output logic                    selected,
    output logic                    wr_done,
    output logic                    cmd_err
);

    localparam int          c_TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [0:0]  c_IDLE  = 1'b0;
    localparam logic [0:0]  c_SEL   = 1'b1;
    localparam logic [CW-1:0] c_M   = {CW{1'b1}};
    localparam logic [CW-1:0] c_Z   = {CW{1'b0}};

    // Palette entries are packed {r,g,b}.
    function automatic logic [3*CW-1:0] pal_default(input logic [1:0] idx);
        case (idx)
            2'd0:    pal_default = {c_M, c_Z, c_Z};
            2'd1:    pal_default = {c_Z, c_M, c_Z};
            2'd2:    pal_default = {c_Z, c_Z, c_M};
            default: pal_default = {c_M, c_M, c_M};
        endcase
    endfunction

    logic [0:0]              r_state;
    logic [CODE_W-1:0]       r_sel;
    logic [c_TMR_W-1:0]      r_timer;
    logic                    r_wr_done;
    logic                    r_cmd_err;
    logic [NUM_CELLS*CW-1:0] r_reds;
    logic [NUM_CELLS*CW-1:0] r_greens;
    logic [NUM_CELLS*CW-1:0] r_blues;

    logic [0:0]              w_nxt_state;
    logic [CODE_W-1:0]       w_nxt_sel;
    logic [c_TMR_W-1:0]      w_nxt_timer;
    logic                    w_wr;
    logic                    w_err;
    logic                    w_clr;
    logic                    w_cell_we;
    logic                    w_is_cell;
    logic                    w_is_col;
    logic [1:0]              w_pidx;
    logic [3*CW-1:0]         w_entry;

    assign w_is_cell = (code != '0) && (code <= CODE_W'(NUM_CELLS));
    assign w_is_col  = (code >= CODE_W'(COL_BASE)) && (code <= CODE_W'(COL_BASE + 3));
    assign w_pidx    = 2'(code - CODE_W'(COL_BASE));

`ifdef CELL_COLOUR_PALETTE_WR_EN
    logic [3*CW-1:0] r_pal [4];

    // Reads see the pre-edge contents, so a same-cycle colour code uses the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_pal[i] <= pal_default(2'(i));
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    assign w_entry = r_pal[w_pidx];
`else
    assign w_entry = pal_default(w_pidx);
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_timer = r_timer;
        w_wr        = 1'b0;
        w_err       = 1'b0;
        w_clr       = 1'b0;
        w_cell_we   = 1'b0;
        if (code_valid) begin
            if (code == '0) begin
                w_clr       = 1'b1;
                w_wr        = 1'b1;
                w_nxt_state = c_IDLE;
                w_nxt_sel   = '0;
                w_nxt_timer = '0;
            end else if (w_is_cell) begin
                w_nxt_state = c_SEL;
                w_nxt_sel   = code;
                w_nxt_timer = '0;
            end else if (w_is_col && (r_state == c_SEL)) begin
                w_cell_we   = 1'b1;
                w_wr        = 1'b1;
                w_nxt_timer = '0;
            end else begin
                w_err = 1'b1;
            end
        end else if ((TIMEOUT_CYC > 0) && (r_state == c_SEL)) begin
            // Idle cycle while selected: age the selection, drop it on expiry.
            if (r_timer == c_TMR_W'(TIMEOUT_CYC - 1)) begin
                w_nxt_state = c_IDLE;
                w_nxt_sel   = '0;
                w_nxt_timer = '0;
            end else begin
                w_nxt_timer = r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_sel     <= '0;
            r_timer   <= '0;
            r_wr_done <= 1'b0;
            r_cmd_err <= 1'b0;
            r_reds    <= '0;
            r_greens  <= '0;
            r_blues   <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_sel     <= w_nxt_sel;
            r_timer   <= w_nxt_timer;
            r_wr_done <= w_wr;
            r_cmd_err <= w_err;
            if (w_clr) begin
                r_reds   <= '0;
                r_greens <= '0;
                r_blues  <= '0;
            end else if (w_cell_we) begin
                for (int k = 0; k < NUM_CELLS; k++) begin
                    if (r_sel == CODE_W'(k + 1)) begin
                        r_reds[k*CW +: CW]   <= w_entry[3*CW-1:2*CW];
                        r_greens[k*CW +: CW] <= w_entry[2*CW-1:CW];
                        r_blues[k*CW +: CW]  <= w_entry[CW-1:0];
                    end
                end
            end
        end
    end

    assign reds     = r_reds;
    assign greens   = r_greens;
    assign blues    = r_blues;
    assign sel_cell = r_sel;
    assign selected = (r_state == c_SEL);
    assign wr_done  = r_wr_done;
    assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_cell_colour_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_colour_map
// Brief    : Directed vector bench for cell_colour_map (default and timeout builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_colour_map;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters (no timeout)
    logic        rst, code_valid;
    logic [3:0]  code;
    logic [26:0] reds, greens, blues;
    logic [3:0]  sel_cell;
    logic        selected, wr_done, cmd_err;

    // Instance B: TIMEOUT_CYC = 4
    logic        t_rst, t_code_valid;
    logic [3:0]  t_code;
    logic [26:0] t_reds, t_greens, t_blues;
    logic [3:0]  t_sel_cell;
    logic        t_selected, t_wr_done, t_cmd_err;

`ifdef CELL_COLOUR_PALETTE_WR_EN
    logic        pal_we;
    logic [1:0]  pal_idx;
    logic [8:0]  pal_data;
    logic        t_pal_we   = 1'b0;
    logic [1:0]  t_pal_idx  = 2'd0;
    logic [8:0]  t_pal_data = 9'd0;
`endif

    cell_colour_map u_dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
`ifdef CELL_COLOUR_PALETTE_WR_EN
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
`endif
        .reds(reds), .greens(greens), .blues(blues), .sel_cell(sel_cell),
        .selected(selected), .wr_done(wr_done), .cmd_err(cmd_err)
    );

    cell_colour_map #(.TIMEOUT_CYC(4)) u_dut_to (
        .clk(clk), .rst(t_rst), .code_valid(t_code_valid), .code(t_code),
`ifdef CELL_COLOUR_PALETTE_WR_EN
        .pal_we(t_pal_we), .pal_idx(t_pal_idx), .pal_data(t_pal_data),
`endif
        .reds(t_reds), .greens(t_greens), .blues(t_blues), .sel_cell(t_sel_cell),
        .selected(t_selected), .wr_done(t_wr_done), .cmd_err(t_cmd_err)
    );

    typedef struct {
        logic        v;
        logic [3:0]  c;
        logic [3:0]  sel;
        logic        seld;
        logic        wr;
        logic        err;
        logic [26:0] r;
        logic [26:0] g;
        logic [26:0] b;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs [17];

    function automatic vec_t mk(input logic v, input logic [3:0] c, input logic [3:0] sel,
                                input logic seld, input logic wr, input logic err,
                                input logic [26:0] r, input logic [26:0] g, input logic [26:0] b);
        vec_t t;
        t.v = v; t.c = c; t.sel = sel; t.seld = seld; t.wr = wr; t.err = err;
        t.r = r; t.g = g; t.b = b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        code_valid = v;
        code       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic tstep(input logic v, input logic [3:0] c);
        t_code_valid = v;
        t_code       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] sel, input logic seld,
                           input logic wr, input logic err,
                           input logic [26:0] r, input logic [26:0] g, input logic [26:0] b);
        chk({name, ".sel_cell"}, 32'(sel_cell), 32'(sel));
        chk({name, ".selected"}, 32'(selected), 32'(seld));
        chk({name, ".wr_done"},  32'(wr_done),  32'(wr));
        chk({name, ".cmd_err"},  32'(cmd_err),  32'(err));
        chk({name, ".reds"},     32'(reds),     32'(r));
        chk({name, ".greens"},   32'(greens),   32'(g));
        chk({name, ".blues"},    32'(blues),    32'(b));
    endtask

    initial begin
        // Cell k occupies bits [3k-1:3k-3]: cell1=0x7, cell3=0x1C0, cell7=0x1C0000, cell9=0x7000000.
        vecs[0]  = mk(1, 4'd3,  4'd3, 1, 0, 0, 27'h0,       27'h0,       27'h0);
        vecs[1]  = mk(1, 4'd11, 4'd3, 1, 1, 0, 27'h0,       27'h1C0,     27'h0);
        vecs[2]  = mk(0, 4'd11, 4'd3, 1, 0, 0, 27'h0,       27'h1C0,     27'h0);
        vecs[3]  = mk(1, 4'd9,  4'd9, 1, 0, 0, 27'h0,       27'h1C0,     27'h0);
        vecs[4]  = mk(1, 4'd13, 4'd9, 1, 1, 0, 27'h7000000, 27'h70001C0, 27'h7000000);
        vecs[5]  = mk(1, 4'd12, 4'd9, 1, 1, 0, 27'h0,       27'h1C0,     27'h7000000);
        vecs[6]  = mk(1, 4'd15, 4'd9, 1, 0, 1, 27'h0,       27'h1C0,     27'h7000000);
        vecs[7]  = mk(1, 4'd10, 4'd9, 1, 1, 0, 27'h7000000, 27'h1C0,     27'h0);
        vecs[8]  = mk(1, 4'd0,  4'd0, 0, 1, 0, 27'h0,       27'h0,       27'h0);
        vecs[9]  = mk(1, 4'd12, 4'd0, 0, 0, 1, 27'h0,       27'h0,       27'h0);
        vecs[10] = mk(1, 4'd1,  4'd1, 1, 0, 0, 27'h0,       27'h0,       27'h0);
        vecs[11] = mk(1, 4'd10, 4'd1, 1, 1, 0, 27'h7,       27'h0,       27'h0);
        vecs[12] = mk(1, 4'd7,  4'd7, 1, 0, 0, 27'h7,       27'h0,       27'h0);
        vecs[13] = mk(1, 4'd14, 4'd7, 1, 0, 1, 27'h7,       27'h0,       27'h0);
        vecs[14] = mk(1, 4'd11, 4'd7, 1, 1, 0, 27'h7,       27'h1C0000,  27'h0);
        vecs[15] = mk(0, 4'd0,  4'd7, 1, 0, 0, 27'h7,       27'h1C0000,  27'h0);
        vecs[16] = mk(1, 4'd0,  4'd0, 0, 1, 0, 27'h0,       27'h0,       27'h0);

        rst = 1'b1; code_valid = 1'b1; code = 4'd3;
        t_rst = 1'b1; t_code_valid = 1'b0; t_code = 4'd0;
`ifdef CELL_COLOUR_PALETTE_WR_EN
        pal_we = 1'b0; pal_idx = 2'd0; pal_data = 9'd0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 27'h0, 27'h0, 27'h0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].c);
            chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].seld, vecs[i].wr,
                    vecs[i].err, vecs[i].r, vecs[i].g, vecs[i].b);
        end

        // Reset in the middle of a selection with a written cell.
        step(1, 4'd4);
        step(1, 4'd13);
        rst = 1'b1;
        step(1, 4'd10);
        rst = 1'b0;
        chk_all("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0, 27'h0, 27'h0, 27'h0);

        // Timeout instance: cell 2 = red (0x38), then four idle cycles expire the selection.
        t_rst = 1'b0;
        tstep(1, 4'd2);
        tstep(1, 4'd10);
        chk("to.write_red", 32'(t_reds), 32'h38);
        for (int i = 0; i < 3; i++) begin
            tstep(0, 4'd0);
            chk($sformatf("to.still_sel%0d", i), 32'(t_selected), 32'd1);
        end
        tstep(0, 4'd0);
        chk("to.dropped", 32'(t_selected), 32'd0);
        chk("to.sel_zero", 32'(t_sel_cell), 32'd0);
        tstep(1, 4'd10);
        chk("to.col_idle_err", 32'(t_cmd_err), 32'd1);
        chk("to.col_idle_wr", 32'(t_wr_done), 32'd0);
        chk("to.reds_kept", 32'(t_reds), 32'h38);

        // A valid code on the expiry cycle wins and restarts the timer.
        tstep(1, 4'd2);
        for (int i = 0; i < 3; i++) tstep(0, 4'd0);
        tstep(1, 4'd11);
        chk("to.expiry_code_sel", 32'(t_selected), 32'd1);
        chk("to.expiry_code_wr", 32'(t_wr_done), 32'd1);
        chk("to.expiry_code_green", 32'(t_greens), 32'h38);
        for (int i = 0; i < 3; i++) tstep(0, 4'd0);
        chk("to.restart_sel", 32'(t_selected), 32'd1);
        tstep(0, 4'd0);
        chk("to.restart_drop", 32'(t_selected), 32'd0);

        // Default instance never times out.
        step(1, 4'd6);
        for (int i = 0; i < 10; i++) step(0, 4'd0);
        chk("notimeout.sel", 32'(sel_cell), 32'd6);

`ifdef CELL_COLOUR_PALETTE_WR_EN
        // Cell 5 occupies bits [14:12].
        pal_we = 1'b1; pal_idx = 2'd0; pal_data = 9'b101_010_001;
        step(0, 4'd0);
        pal_we = 1'b0;
        step(1, 4'd5);
        step(1, 4'd10);
        chk("pal.reds", 32'(reds), 32'h5000);
        chk("pal.greens", 32'(greens), 32'h2000);
        chk("pal.blues", 32'(blues), 32'h1000);
        // Same-cycle palette write and colour code: old entry is used.
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 9'd0;
        step(1, 4'd11);
        pal_we = 1'b0;
        chk("pal.rbw_greens", 32'(greens), 32'h7000);
        step(1, 4'd11);
        chk("pal.new_greens", 32'(greens), 32'h0);
        rst = 1'b1;
        step(0, 4'd0);
        rst = 1'b0;
        step(1, 4'd5);
        step(1, 4'd10);
        chk("pal.reset_reds", 32'(reds), 32'h7000);
        chk("pal.reset_greens", 32'(greens), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cell_colour_map.md
Name: cell_colour_map

Overview:
- Keypad-driven colour register file for the VGA display path.
- A 4-bit key code first selects one of NUM_CELLS screen cells, then a colour code; the chosen palette colour is written into that cell's slot in flat red/green/blue vectors read by the pixel generator.
- Generalises the fixed 9-cell/3-bit scheme: parameterised cell count, channel depth and code map, plus a selection timeout, clear-all command and status strobes.

Parameters:
- NUM_CELLS, 9, number of addressable cells (1..COL_BASE-1).
- CW, 3, bits per colour channel per cell.
- CODE_W, 4, key code width.
- COL_BASE, 10, first colour code; codes COL_BASE..COL_BASE+3 map to palette entries 0..3; COL_BASE+3 < 2**CODE_W.
- TIMEOUT_CYC, 0, idle cycles in SEL before selection drops; 0 = never; counter width $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- code_valid  in  1  code qualifier, sampled on rising clk.
- code  in  CODE_W  key code.
- reds  out  NUM_CELLS*CW  cell k (1-based) at [k*CW-1:(k-1)*CW].
- greens  out  NUM_CELLS*CW  same packing.
- blues  out  NUM_CELLS*CW  same packing.
- sel_cell  out  CODE_W  currently selected cell, 0 = none.
- selected  out  1  high in state SEL.
- wr_done  out  1  one-cycle pulse after a cell write.
- cmd_err  out  1  one-cycle pulse on a rejected code.

Behaviour:
- Reset (rst=1 at clk edge) takes priority over everything:
  - reds/greens/blues = 0, sel_cell = 0, selected = 0, wr_done = 0, cmd_err = 0.
  - Timer = 0, state IDLE, palette restored to its default.
- Default palette (M = all-ones CW):
  - 0 red (M,0,0); 1 green (0,M,0); 2 blue (0,0,M); 3 white (M,M,M).
- States IDLE and SEL. Only cycles with code_valid=1 act on code. All outputs are registered; effects are visible the cycle after the sampling edge.
- code == 0 (any state): all three vectors cleared to 0, sel_cell = 0, go to IDLE, wr_done pulses.
- code 1..NUM_CELLS (any state): sel_cell = code, go to SEL, timer = 0. Re-selecting in SEL just moves the selection; no colour is written.
- Colour code in SEL: the selected cell's three CW-bit slices load the palette entry, wr_done pulses, state stays SEL, timer = 0. Repeated colour codes recolour the same cell.
- Colour code in IDLE: no write, cmd_err pulses.
- Any other code (NUM_CELLS+1..COL_BASE-1, or above COL_BASE+3): ignored, cmd_err pulses, state and timer unchanged.
- Timeout (TIMEOUT_CYC > 0):
  - In SEL, the timer increments on each cycle without a valid code.
  - Timer reaching TIMEOUT_CYC-1 returns to IDLE with sel_cell = 0 on the next edge. Cell contents are kept.
  - A valid code on the expiry cycle wins over the timeout.
- Cells not addressed by a write hold their value indefinitely.
- wr_done and cmd_err are never high in the same cycle.

Optional Feature:
- Macro CELL_COLOUR_PALETTE_WR_EN.
- Defined:
  - Adds ports pal_we (in, 1), pal_idx (in, 2) and pal_data (in, 3*CW, packed {r,g,b}).
  - pal_we=1 writes pal_data into palette[pal_idx] at the edge.
  - A colour code in the same cycle uses the old entry (read-before-write).
  - Reset restores the defaults.
- Undefined: those ports are absent and the palette is constant.

Test Plan:
- rst 1 cycle -> all vectors 0, sel_cell=0, selected=0.
- code 3 then code 11, default params -> greens[8:6]=3'b111, reds[8:6]=0, blues[8:6]=0, wr_done pulse one cycle after code 11, other cells 0.
- Cell 9 set to 13, then code 0 -> all 27 bits of each vector 0, selected=0, wr_done pulse.
- Code 12 in IDLE -> cmd_err pulse, no change; code 15 in SEL -> cmd_err pulse, sel_cell unchanged.
- TIMEOUT_CYC=4:
  - code 2 then 4 idle cycles -> selected drops to 0.
  - A subsequent code 10 -> cmd_err, reds[5:3] unchanged.
- Macro on:
  - pal_we with idx 0, data {3'b101,3'b010,3'b001}, then code 5, code 10 -> reds[14:12]=101, greens[14:12]=010, blues[14:12]=001.
  - rst -> palette entry 0 back to red.
